hazard_stall_ctrl: RTL

Parametrised load-use and multi-cycle hazard controller for the in-order pipeline, sitting between ID and EX and driving PC, IF/ID and ID/EX control. It detects load-use hazards with configurable load latency, holds the front end and EX stage for multi-cycle EX operations, and suppresses false hazards on the zero register and unused source operands. It also gates taken-branch flushes against stalls and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use / multi-cycle hazard controller between ID and EX.
// Drives PC, IF/ID and ID/EX control and keeps a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int LOAD_LAT    = 1,
    parameter int MC_LAT      = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] ID_Rs1,
    input  logic [REG_ADDR_W-1:0] ID_Rs2,
    input  logic                  ID_Rs1_Used,
    input  logic                  ID_Rs2_Used,
    input  logic [REG_ADDR_W-1:0] EX_Rd,
    input  logic                  EX_MemRead,
    input  logic                  EX_MultiCycle,
    input  logic                  Branch_Taken,
    input  logic                  Cnt_Clr,
    output logic                  NoOp,
    output logic                  PCWrite,
    output logic                  Stall_o,
    output logic                  ExHold_o,
    output logic                  Flush_o,
    output logic                  Busy_o,
    output logic [CNT_W-1:0]      Stall_Cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] LD_CNT_INIT = 4'(LOAD_LAT - 1);
    localparam logic [3:0] MC_CNT_INIT = 4'(MC_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0] src_used;
    logic [1:0] src_hit;
    logic zero_rd;
    logic hit;
    logic load_hz;

    assign src_addr[0] = ID_Rs1;
    assign src_addr[1] = ID_Rs2;
    assign src_used    = {ID_Rs2_Used, ID_Rs1_Used};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_addr[gi] == EX_Rd);
        end
    endgenerate

    // A write to the hardwired zero register can never feed a dependent read.
    assign zero_rd = (ZERO_REG_EN != 0) && (EX_Rd == '0);
    assign hit     = (|src_hit) && !zero_rd;
    assign load_hz = EX_MemRead && hit;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        NoOp       = 1'b0;
        PCWrite    = 1'b1;
        Stall_o    = 1'b0;
        ExHold_o   = 1'b0;
        Flush_o    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (EX_MultiCycle) begin
                    Stall_o  = 1'b1;
                    PCWrite  = 1'b0;
                    ExHold_o = 1'b1;
                    if (MC_LAT > 2) begin
                        cnt_next   = MC_CNT_INIT;
                        state_next = MC_BUSY;
                    end
                end else if (load_hz) begin
                    NoOp    = 1'b1;
                    PCWrite = 1'b0;
                    Stall_o = 1'b1;
                    if (LOAD_LAT > 1) begin
                        cnt_next   = LD_CNT_INIT;
                        state_next = LD_STALL;
                    end
                end else if (Branch_Taken) begin
                    Flush_o = 1'b1;
                end
            end
            LD_STALL: begin
                NoOp     = 1'b1;
                PCWrite  = 1'b0;
                Stall_o  = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = IDLE;
            end
            MC_BUSY: begin
                Stall_o  = 1'b1;
                PCWrite  = 1'b0;
                ExHold_o = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // IDLE outputs follow live inputs, so reset must mask them explicitly.
        if (!rst_i) begin
            NoOp     = 1'b0;
            PCWrite  = 1'b1;
            Stall_o  = 1'b0;
            ExHold_o = 1'b0;
            Flush_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else if (Cnt_Clr) begin
            stall_cnt_reg <= '0;
        end else if (Stall_o && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign Busy_o      = (state_reg != IDLE);
    assign Stall_Cnt_o = stall_cnt_reg;

endmodule
